// File: rtl/alu_stateful.sv
// alu_stateful
// ------------
// Stateful ALU for one action-engine container slot. Each cycle it can accept
// one sub-action: header arithmetic, a load/store, or an atomic read-modify-
// write on a private key-value memory. The result container comes back with
// a fixed two-cycle latency.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous, active-high reset
//   action_in            sub-action word; opcode sits in the top four bits
//   action_valid         qualifies action_in and the operands
//   operand_1_in         header operand / store data / fetch-add increment
//   operand_2_in         second operand or immediate; low bits are the address
//   operand_3_in         original container value, used as pass-through
//   container_out        result container (holds while no result is produced)
//   container_out_valid  one-cycle pulse per accepted action
//
// Pipeline shape:
//   edge k   : action captured in stage 1, RAM address presented
//   edge k+1 : action moves to stage 2, RAM read data registered
//   edge k+2 : result registered, memory write-back committed
// An action one slot behind a writer reads the RAM on the same edge the write
// lands, so it would see stale read-first data. A bypass register captures
// the writer's data on that edge and replaces the RAM output.

module alu_stateful #(
   parameter int ACTION_LEN = 25,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ACTION_LEN-1:0] action_in,
   input  logic                  action_valid,
   input  logic [DATA_WIDTH-1:0] operand_1_in,
   input  logic [DATA_WIDTH-1:0] operand_2_in,
   input  logic [DATA_WIDTH-1:0] operand_3_in,
   output logic [DATA_WIDTH-1:0] container_out,
   output logic                  container_out_valid
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [3:0] {
      OP_ADD    = 4'b0001,
      OP_SUB    = 4'b0010,
      OP_STORE  = 4'b1000,
      OP_ADDI   = 4'b1001,
      OP_SUBI   = 4'b1010,
      OP_LOAD   = 4'b1011,
      OP_FADD   = 4'b1100,
      OP_SATINC = 4'b1101
   } aluOpT;

   logic                  s1Valid;
   logic [3:0]            s1Op;
   logic [DATA_WIDTH-1:0] s1Op1;
   logic [DATA_WIDTH-1:0] s1Op2;
   logic [DATA_WIDTH-1:0] s1Op3;
   logic [ADDR_WIDTH-1:0] s1Addr;

   logic                  s2Valid;
   logic [3:0]            s2Op;
   logic [DATA_WIDTH-1:0] s2Op1;
   logic [DATA_WIDTH-1:0] s2Op2;
   logic [DATA_WIDTH-1:0] s2Op3;
   logic [ADDR_WIDTH-1:0] s2Addr;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] ramQ;
   logic                  bypHit;
   logic [DATA_WIDTH-1:0] bypData;

   logic [DATA_WIDTH-1:0] memValue;
   logic [DATA_WIDTH-1:0] s2Result;
   logic [DATA_WIDTH-1:0] s2WbData;
   logic                  s2WrEn;
   logic                  memWe;

   logic                  unusedBits;

   // Only the opcode field of the action word matters to this slot; the
   // remaining bits are folded into a sink so they are visibly ignored.
   assign unusedBits = ^action_in[ACTION_LEN-5:0];

   // A write only happens for a live stage-2 action whose opcode modifies
   // memory. Reset clears s2Valid, so a half-finished write is dropped.
   assign memWe = s2Valid && s2WrEn;

   // Simple dual-port RAM: one write port driven from stage 2, one
   // synchronous read port addressed from stage 1. The read returns the
   // old contents when it hits the address being written on the same edge,
   // which is what the bypass register corrects for. No reset here so the
   // array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[s2Addr] <= s2WbData;
      end
      ramQ <= mem[s1Addr];
   end

   // Pipeline registers. Stage 1 captures the incoming action, stage 2
   // follows one edge later, and the output register takes the stage-2
   // result. The bypass flag is set when the stage-2 writer targets the
   // address stage 1 is reading on this same edge; its data then replaces
   // the stale RAM word for the following action. The output container only
   // updates on a valid result so bubbles leave it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid             <= 1'b0;
         s1Op                <= '0;
         s1Op1               <= '0;
         s1Op2               <= '0;
         s1Op3               <= '0;
         s1Addr              <= '0;
         s2Valid             <= 1'b0;
         s2Op                <= '0;
         s2Op1               <= '0;
         s2Op2               <= '0;
         s2Op3               <= '0;
         s2Addr              <= '0;
         bypHit              <= 1'b0;
         bypData             <= '0;
         container_out       <= '0;
         container_out_valid <= 1'b0;
      end else begin
         s1Valid             <= action_valid;
         s1Op                <= action_in[ACTION_LEN-1 -: 4];
         s1Op1               <= operand_1_in;
         s1Op2               <= operand_2_in;
         s1Op3               <= operand_3_in;
         s1Addr              <= operand_2_in[ADDR_WIDTH-1:0];
         s2Valid             <= s1Valid;
         s2Op                <= s1Op;
         s2Op1               <= s1Op1;
         s2Op2               <= s1Op2;
         s2Op3               <= s1Op3;
         s2Addr              <= s1Addr;
         bypHit              <= memWe && (s2Addr == s1Addr);
         bypData             <= s2WbData;
         container_out_valid <= s2Valid;
         if (s2Valid) begin
            container_out <= s2Result;
         end
      end
   end

   // Stage-2 datapath. The memory word is the forwarded write data when the
   // previous action wrote this address, otherwise the RAM output. Unknown
   // opcodes fall through to the pass-through container with no write.
   // Saturating increment reports the new value, fetch-add reports the old.
   always_comb begin
      memValue = bypHit ? bypData : ramQ;
      s2Result = s2Op3;
      s2WbData = memValue;
      s2WrEn   = 1'b0;
      case (s2Op)
         OP_ADD, OP_ADDI: begin
            s2Result = s2Op1 + s2Op2;
         end
         OP_SUB, OP_SUBI: begin
            s2Result = s2Op1 - s2Op2;
         end
         OP_STORE: begin
            s2WbData = s2Op1;
            s2WrEn   = 1'b1;
         end
         OP_LOAD: begin
            s2Result = memValue;
         end
         OP_FADD: begin
            s2Result = memValue;
            s2WbData = memValue + s2Op1;
            s2WrEn   = 1'b1;
         end
         OP_SATINC: begin
            s2WbData = (memValue == '1) ? memValue : memValue + ONE;
            s2Result = (memValue == '1) ? memValue : memValue + ONE;
            s2WrEn   = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_alu_stateful.sv
// tb_alu_stateful
// ---------------
// Directed bench for alu_stateful. Each driven action pushes its expected
// container value and the cycle it must appear on into a scoreboard queue.
// A monitor pops entries as results emerge and also checks that no valid
// pulse appears when none is due and that the output holds between results.

module tb_alu_stateful;

   localparam int ACTION_LEN = 25;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   localparam logic [3:0] OP_ADD    = 4'b0001;
   localparam logic [3:0] OP_SUB    = 4'b0010;
   localparam logic [3:0] OP_STORE  = 4'b1000;
   localparam logic [3:0] OP_ADDI   = 4'b1001;
   localparam logic [3:0] OP_SUBI   = 4'b1010;
   localparam logic [3:0] OP_LOAD   = 4'b1011;
   localparam logic [3:0] OP_FADD   = 4'b1100;
   localparam logic [3:0] OP_SATINC = 4'b1101;
   localparam logic [3:0] OP_OTHER  = 4'b0111;

   typedef struct {
      int unsigned           due;
      logic [DATA_WIDTH-1:0] data;
   } expT;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [ACTION_LEN-1:0] action_in = '0;
   logic                  action_valid = 1'b0;
   logic [DATA_WIDTH-1:0] operand_1_in = '0;
   logic [DATA_WIDTH-1:0] operand_2_in = '0;
   logic [DATA_WIDTH-1:0] operand_3_in = '0;
   logic [DATA_WIDTH-1:0] container_out;
   logic                  container_out_valid;

   expT                   sb[$];
   int unsigned           cycle = 0;
   int                    errors = 0;
   int                    checks = 0;
   logic [DATA_WIDTH-1:0] lastOut = '0;

   alu_stateful #(
      .ACTION_LEN(ACTION_LEN),
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .action_in          (action_in),
      .action_valid       (action_valid),
      .operand_1_in       (operand_1_in),
      .operand_2_in       (operand_2_in),
      .operand_3_in       (operand_3_in),
      .container_out      (container_out),
      .container_out_valid(container_out_valid)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch counts the failure and
   // reports the tag with both values.
   task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] observed,
                              input logic [DATA_WIDTH-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one action for a single cycle and records the value it must
   // produce two edges after it is sampled.
   task automatic applyStimulus(input logic [3:0] op, input logic [DATA_WIDTH-1:0] op1,
                                input logic [DATA_WIDTH-1:0] op2, input logic [DATA_WIDTH-1:0] op3,
                                input logic [DATA_WIDTH-1:0] expected);
      @(negedge clk);
      action_in    = {op, {(ACTION_LEN-4){1'b0}}};
      action_valid = 1'b1;
      operand_1_in = op1;
      operand_2_in = op2;
      operand_3_in = op3;
      sb.push_back('{cycle + 3, expected});
   endtask

   // Idle cycle with garbage operands to show bubbles are really ignored.
   task automatic applyBubble(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         action_in    = {OP_STORE, {(ACTION_LEN-4){1'b0}}};
         action_valid = 1'b0;
         operand_1_in = $urandom;
         operand_2_in = $urandom;
         operand_3_in = $urandom;
      end
   endtask

   // Monitor, sampling 1 ns after every rising edge. The cycle number here
   // is the count of edges seen; an action sampled on edge N is due on N+2.
   always @(posedge clk) begin
      #1;
      cycle++;
      if (sb.size() > 0 && sb[0].due < cycle) begin
         checks++;
         errors++;
         $error("[TB] FAIL missed_result: observed=none expected=%h due=%0d", sb[0].data, sb[0].due);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cycle) begin
         checkOutput($sformatf("valid@%0d", cycle), {31'b0, container_out_valid}, 32'd1);
         checkOutput($sformatf("data@%0d", cycle), container_out, sb[0].data);
         lastOut = sb[0].data;
         void'(sb.pop_front());
      end else begin
         checkOutput($sformatf("novalid@%0d", cycle), {31'b0, container_out_valid}, 32'd0);
         checkOutput($sformatf("hold@%0d", cycle), container_out, lastOut);
      end
   end

   // Directed sequence: arithmetic, pass-through, store/load with bypass
   // and aliasing, fetch-add chain, saturation, then reset mid-flight.
   initial begin
      $display("[TB] start");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      applyStimulus(OP_ADD, 32'd5, 32'd7, 32'h0, 32'd12);
      applyBubble(3);

      applyStimulus(OP_SUB,   32'd3,   32'd5,  32'h0,  32'hFFFF_FFFE);
      applyStimulus(OP_OTHER, 32'd9,   32'd9,  32'h55, 32'h55);
      applyStimulus(OP_ADDI,  32'd100, 32'd23, 32'h0,  32'd123);
      applyStimulus(OP_SUBI,  32'd10,  32'd4,  32'h0,  32'd6);
      applyBubble(2);

      applyStimulus(OP_STORE, 32'hDEAD_BEEF, 32'd3,  32'h11, 32'h11);
      applyStimulus(OP_LOAD,  32'h0,         32'd3,  32'h0,  32'hDEAD_BEEF);
      applyStimulus(OP_LOAD,  32'h0,         32'd35, 32'h0,  32'hDEAD_BEEF);
      applyBubble(2);

      applyStimulus(OP_STORE,  32'd10, 32'd7, 32'h99, 32'h99);
      applyStimulus(OP_FADD,   32'd1,  32'd7, 32'h0,  32'd10);
      applyStimulus(OP_FADD,   32'd1,  32'd7, 32'h0,  32'd11);
      applyStimulus(OP_FADD,   32'd1,  32'd7, 32'h0,  32'd12);
      applyStimulus(OP_LOAD,   32'd0,  32'd7, 32'h0,  32'd13);
      applyStimulus(OP_SATINC, 32'd0,  32'd7, 32'h0,  32'd14);
      applyBubble(2);

      applyStimulus(OP_STORE,  32'hFFFF_FFFE, 32'd1, 32'h22, 32'h22);
      applyStimulus(OP_SATINC, 32'h0,         32'd1, 32'h0,  32'hFFFF_FFFF);
      applyStimulus(OP_SATINC, 32'h0,         32'd1, 32'h0,  32'hFFFF_FFFF);
      applyStimulus(OP_LOAD,   32'h0,         32'd1, 32'h0,  32'hFFFF_FFFF);
      applyBubble(2);

      applyStimulus(OP_STORE, 32'h1234, 32'd9, 32'h33, 32'h33);
      applyBubble(1);
      applyStimulus(OP_LOAD,  32'h0,    32'd9, 32'h0,  32'h1234);
      applyBubble(3);

      applyStimulus(OP_STORE, 32'hAAAA, 32'd2, 32'h77, 32'h77);
      applyStimulus(OP_ADD,   32'd1,    32'd1, 32'h0,  32'd2);
      applyStimulus(OP_STORE, 32'hBBBB, 32'd2, 32'h66, 32'h66);
      @(negedge clk);
      rst          = 1'b1;
      action_valid = 1'b0;
      sb.delete();
      lastOut      = '0;
      #1;
      checkOutput("rst_container", container_out, 32'h0);
      checkOutput("rst_valid", {31'b0, container_out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyBubble(2);
      applyStimulus(OP_LOAD, 32'h0, 32'd2, 32'h0, 32'hAAAA);
      applyBubble(6);

      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_stateful.md
# alu_stateful

Parametrised, fully pipelined stateful ALU for one RMT action-engine container slot. It executes one sub-action per cycle from the action decoder: header arithmetic, load/store, and atomic read-modify-write on a private key-value memory. It returns the result container to PHV formation with a fixed 2-cycle latency. Back-to-back accesses to the same memory address are hazard-free.

## Interface
Parameters:
- `ACTION_LEN`, 25, action word width; opcode is `action_in[ACTION_LEN-1 -: 4]`.
- `DATA_WIDTH`, 32, operand, container and memory word width.
- `ADDR_WIDTH`, 5, memory address width; depth is 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `action_in`  in  ACTION_LEN  sub-action word.
- `action_valid`  in  1  qualifies `action_in` and the operands. One action per cycle; no backpressure.
- `operand_1_in`  in  DATA_WIDTH  header operand / store data / RMW increment.
- `operand_2_in`  in  DATA_WIDTH  second operand or immediate. Bits `[ADDR_WIDTH-1:0]` are the memory address `a`.
- `operand_3_in`  in  DATA_WIDTH  original container value, used as pass-through.
- `container_out`  out  DATA_WIDTH  result container.
- `container_out_valid`  out  1  one-cycle pulse per accepted action.

## Operation
- Opcodes; `m` is the memory word at `a`, and all arithmetic is modulo 2^DATA_WIDTH:
  - `0001` add, `1001` addi: out = op1 + op2.
  - `0010` sub, `1010` subi: out = op1 − op2, wrapping.
  - `1000` store: m ← op1; out = op3.
  - `1011` load: out = m.
  - `1100` fetch-add: out = old m; m ← old m + op1.
  - `1101` saturating increment: m ← (m == all-ones) ? m : m+1; out = new m.
  - Any other opcode: out = op3, no memory write. This is still a valid action and still produces a valid pulse.
- Pipeline:
  - S1 (edge k): register opcode, operands and `a`; issue the synchronous RAM read at `a`.
  - S2 (edge k+1): RAM data is available. Compute the result and write-back value.
  - Edge k+2: register `container_out` and `container_out_valid`; commit the memory write for store, fetch-add and sat-inc.
- Memory:
  - Inferable simple dual-port RAM: synchronous read, read-first, one write port.
  - Contents are not cleared by reset and power up as 0.
- Hazard bypass:
  - If the S2 action writes address X and the S1 action reads X in the same cycle, S1 captures the S2 write data instead of the stale RAM output.
  - Distance-2 accesses need no bypass: the write has committed before the read edge.
  - Result: every action sees the memory state left by all earlier actions, regardless of spacing.
- When `action_valid` is low, the bubble propagates: no write, no valid pulse, and `container_out` holds its last value.

## Timing
- Latency: action sampled at edge k → `container_out_valid`=1 after edge k+2, for exactly one cycle.
- Throughput: 1 action/cycle. N consecutive actions produce N consecutive valid cycles, in order.
- Reset values: `container_out`=0, `container_out_valid`=0, and all pipeline valid/opcode/address registers = 0.
- Reset mid-operation:
  - Asserting `rst` discards all in-flight actions immediately.
  - A write not yet committed (edge k+2 not reached) never occurs.
  - The first action after deassertion behaves normally with full 2-cycle latency.
- Simultaneous events:
  - An S2 write and S1 read to the same address resolve by bypass (write data wins).
  - A write and an external read at the same edge cannot occur, because the port is internal.
- Address aliasing: operand_2 bits above `ADDR_WIDTH` are ignored.
- A sat-inc at all-ones still produces a valid output of all-ones.

## Test plan
1. Add: add, op1=5, op2=7, at edge k → out=12 after edge k+2; valid high 1 cycle.
2. Sub wrap: sub, op1=3, op2=5 → out=0xFFFFFFFE. An unknown opcode `0111` with op3=0x55 on the next cycle → out=0x55, consecutive valids.
3. Store/load bypass: store a=3, op1=0xDEADBEEF, op3=0x11, then load a=3 the next cycle → outputs 0x11 then 0xDEADBEEF. Load a=35 (aliases to 3) → 0xDEADBEEF.
4. RMW chain: store a=7, op1=10, then 3× back-to-back fetch-add a=7, op1=1, then load a=7 → outputs op3, 10, 11, 12, 13.
5. Saturation: store a=1, op1=0xFFFFFFFE, then 2× consecutive sat-inc a=1 → outputs 0xFFFFFFFF, 0xFFFFFFFF; a following load → 0xFFFFFFFF.
6. Reset mid-flight:
   - Setup: store a=2, op1=0xAAAA; then store a=2, op1=0xBBBB at edge k.
   - Stimulus: `rst` asserted between edge k and k+1.
   - Required: `container_out`=0 and valid=0 immediately; no valid pulse for the second store; a load a=2 after release → 0xAAAA.
